// File: rtl/demux1t8_32_reg.sv
// Registered 1-to-8 word distributor: writes D into one of eight holding
// registers, chosen by explicit select or an auto-incrementing pointer.
module demux1t8_32_reg #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D,
  input  logic [2:0]        s,
  input  logic              we,
  input  logic              auto,
  output logic [DATA_W-1:0] O0,
  output logic [DATA_W-1:0] O1,
  output logic [DATA_W-1:0] O2,
  output logic [DATA_W-1:0] O3,
  output logic [DATA_W-1:0] O4,
  output logic [DATA_W-1:0] O5,
  output logic [DATA_W-1:0] O6,
  output logic [DATA_W-1:0] O7,
  output logic [2:0]        ptr,
  output logic [7:0]        upd,
  output logic              wrap
);

  logic [DATA_W-1:0] regs [8];
  logic [2:0]        tgt;

  assign tgt = auto ? ptr : s;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values of ptr and the inputs, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the holding registers are reset because downstream selectors
      // read them directly; eight words is small enough that this is cheap.
      for (int i = 0; i < 8; i++) regs[i] <= INIT;
      ptr  <= '0;
      upd  <= '0;
      wrap <= 1'b0;
    end else begin
      upd  <= '0;
      wrap <= 1'b0;
      if (we) begin
        regs[tgt] <= D;
        upd       <= 8'b1 << tgt;
        // An explicit write also reseats the pointer just past its target.
        ptr       <= tgt + 3'd1;
        wrap      <= auto && (ptr == 3'd7);
      end
    end
  end

  assign O0 = regs[0];
  assign O1 = regs[1];
  assign O2 = regs[2];
  assign O3 = regs[3];
  assign O4 = regs[4];
  assign O5 = regs[5];
  assign O6 = regs[6];
  assign O7 = regs[7];

endmodule

// File: tb/tb_demux1t8_32_reg.sv
// Directed bench for demux1t8_32_reg: reset priority, explicit and auto writes,
// wrap pulse, hold behaviour, mode mixing and reset in the middle of a burst.
module tb_demux1t8_32_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] D;
  logic [2:0]  s;
  logic        we;
  logic        auto;
  logic [31:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic [2:0]  ptr;
  logic [7:0]  upd;
  logic        wrap;

  logic [31:0] o_arr [8];
  logic [31:0] exp_o [8];
  int          n_checks = 0;
  int          n_pass   = 0;

  demux1t8_32_reg #(.DATA_W(32), .INIT(32'h0)) dut (
    .clk(clk), .rst(rst), .D(D), .s(s), .we(we), .auto(auto),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7),
    .ptr(ptr), .upd(upd), .wrap(wrap)
  );

  always #5 clk = ~clk;

  assign o_arr[0] = O0;
  assign o_arr[1] = O1;
  assign o_arr[2] = O2;
  assign o_arr[3] = O3;
  assign o_arr[4] = O4;
  assign o_arr[5] = O5;
  assign o_arr[6] = O6;
  assign o_arr[7] = O7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s O%0d", tag, i), o_arr[i], exp_o[i]);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 8; i++) exp_o[i] = 32'h0;
  endtask

  // Advance one rising edge and sample outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] oh;

    // Reset held with a pending write: no write may land.
    rst = 1'b1; we = 1'b1; D = 32'hFFFF_FFFF; s = 3'd2; auto = 1'b0;
    tick(); tick();
    clear_exp();
    check_regs("reset");
    check("reset ptr",  32'(ptr),  32'd0);
    check("reset upd",  32'(upd),  32'h00);
    check("reset wrap", 32'(wrap), 32'd0);

    // Explicit writes.
    rst = 1'b0; auto = 1'b0; we = 1'b1;
    s = 3'd3; D = 32'hDEAD_BEEF;
    tick();
    check("expl1 upd", 32'(upd), 32'h08);
    check("expl1 ptr", 32'(ptr), 32'd4);
    check("expl1 O3",  O3,       32'hDEAD_BEEF);
    s = 3'd0; D = 32'h1234_5678;
    tick();
    check("expl2 upd",  32'(upd),  32'h01);
    check("expl2 ptr",  32'(ptr),  32'd1);
    check("expl2 wrap", 32'(wrap), 32'd0);
    exp_o[3] = 32'hDEAD_BEEF; exp_o[0] = 32'h1234_5678;
    check_regs("expl");

    // Repeated write to the same index keeps the same strobe bit high.
    s = 3'd2; D = 32'hAAAA_0001;
    tick();
    check("same1 upd", 32'(upd), 32'h04);
    D = 32'hAAAA_0002;
    tick();
    check("same2 upd", 32'(upd), 32'h04);
    check("same2 O2",  O2,       32'hAAAA_0002);

    // Auto burst of 9 from a fresh reset; the 8th write wraps.
    rst = 1'b1; we = 1'b0;
    tick();
    rst = 1'b0; auto = 1'b1; we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      D = 32'(i + 1);
      tick();
      oh = 8'd1 << (i % 8);
      check($sformatf("burst%0d ptr", i),  32'(ptr),  32'((i + 1) % 8));
      check($sformatf("burst%0d upd", i),  32'(upd),  32'(oh));
      check($sformatf("burst%0d wrap", i), 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
    end
    exp_o[0] = 32'd9;
    for (int i = 1; i < 8; i++) exp_o[i] = 32'(i + 1);
    check_regs("burst");

    // Hold: we=0 with other inputs toggling.
    we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      D = $urandom; s = 3'($urandom_range(0, 7)); auto = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("hold%0d ptr", i),  32'(ptr),  32'd1);
      check($sformatf("hold%0d upd", i),  32'(upd),  32'h00);
      check($sformatf("hold%0d wrap", i), 32'(wrap), 32'd0);
    end
    check_regs("hold");

    // Mode mix: explicit to 5, then auto continues at 6, then 7 with wrap.
    we = 1'b1; auto = 1'b0; s = 3'd5; D = 32'hA5A5_A5A5;
    tick();
    check("mix1 ptr", 32'(ptr), 32'd6);
    auto = 1'b1; s = 3'd1; D = 32'h5A5A_5A5A;
    tick();
    check("mix2 ptr",  32'(ptr),  32'd7);
    check("mix2 upd",  32'(upd),  32'h40);
    check("mix2 wrap", 32'(wrap), 32'd0);
    exp_o[5] = 32'hA5A5_A5A5; exp_o[6] = 32'h5A5A_5A5A;
    check_regs("mix");
    D = 32'h0000_C0DE;
    tick();
    check("mix3 ptr",  32'(ptr),  32'd0);
    check("mix3 upd",  32'(upd),  32'h80);
    check("mix3 wrap", 32'(wrap), 32'd1);
    check("mix3 O7",   O7,        32'h0000_C0DE);

    // Explicit write to 7 must not raise wrap.
    auto = 1'b0; s = 3'd7; D = 32'h0000_0707;
    tick();
    check("expl7 ptr",  32'(ptr),  32'd0);
    check("expl7 wrap", 32'(wrap), 32'd0);

    // Reset mid-burst: burst up to ptr=4, reset with we=1, then one auto write.
    rst = 1'b1; we = 1'b0;
    tick();
    rst = 1'b0; auto = 1'b1; we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = 32'h10 + 32'(i);
      tick();
    end
    check("mid pre ptr", 32'(ptr), 32'd4);
    check("mid pre O3",  O3,       32'h13);
    rst = 1'b1; D = 32'hFFFF_FFFF;
    tick();
    clear_exp();
    check_regs("mid rst");
    check("mid rst ptr", 32'(ptr), 32'd0);
    check("mid rst upd", 32'(upd), 32'h00);
    rst = 1'b0; D = 32'h77;
    tick();
    exp_o[0] = 32'h77;
    check_regs("mid post");
    check("mid post upd", 32'(upd), 32'h01);
    check("mid post ptr", 32'(ptr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
